// File: rtl/store_buffer.sv
// Posted-write FIFO between the MEM-stage store path and the word-addressed data memory.
// Define STORE_FWD_EN to forward matching buffered stores to loads instead of stalling them.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   st_valid_i,
  output logic                   st_ready_o,
  input  logic [AW-1:0]          st_addr_i,
  input  logic [AW-1:0]          st_data_i,
  input  logic                   ld_valid_i,
  input  logic [AW-1:0]          ld_addr_i,
  output logic                   ld_stall_o,
  output logic                   ld_fwd_hit_o,
  output logic [AW-1:0]          ld_fwd_data_o,
  output logic [AW-1:0]          mem_addr_o,
  output logic [AW-1:0]          mem_wdata_o,
  output logic                   mem_write_o,
  output logic                   mem_read_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    ARB_FULL,
    ARB_LOAD,
    ARB_MATCH,
    ARB_DRAIN,
    ARB_IDLE
  } arb_e;

  // Only the word address is kept; byte-offset bits never reach memory.
  logic [AW-3:0] entryAddr_q [DEPTH];
  logic [AW-1:0] entryData_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;
  logic          match;
  logic [AW-1:0] matchData;
  logic          unusedBits;
  arb_e          arb;

  assign st_ready_o = (count_q < CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign push       = st_valid_i && st_ready_o;
  assign pop        = mem_write_o;

  // Scan oldest to youngest so the youngest matching entry overwrites earlier hits.
  always_comb begin
    match     = 1'b0;
    matchData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ld_valid_i && (CW'(i) < count_q) &&
          (entryAddr_q[head_q + PW'(i)] == ld_addr_i[AW-1:2])) begin
        match     = 1'b1;
        matchData = entryData_q[head_q + PW'(i)];
      end
    end
  end

  always_comb begin
    if (count_q == CW'(DEPTH))     arb = ARB_FULL;
    else if (ld_valid_i && !match) arb = ARB_LOAD;
    else if (ld_valid_i)           arb = ARB_MATCH;
    else if (count_q != '0)        arb = ARB_DRAIN;
    else                           arb = ARB_IDLE;
  end

  always_comb begin
    mem_write_o   = 1'b0;
    mem_read_o    = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    ld_stall_o    = 1'b0;
    ld_fwd_hit_o  = 1'b0;
    ld_fwd_data_o = '0;
    case (arb)
      ARB_FULL, ARB_MATCH, ARB_DRAIN: begin
        mem_write_o = 1'b1;
        mem_addr_o  = {entryAddr_q[head_q], 2'b00};
        mem_wdata_o = entryData_q[head_q];
      end
      ARB_LOAD: begin
        mem_read_o = 1'b1;
        mem_addr_o = ld_addr_i;
      end
      default: ;
    endcase
`ifdef STORE_FWD_EN
    if ((arb == ARB_FULL || arb == ARB_MATCH) && match) begin
      ld_fwd_hit_o  = 1'b1;
      ld_fwd_data_o = matchData;
    end
    ld_stall_o = (arb == ARB_FULL) && ld_valid_i && !match;
`else
    ld_stall_o = (arb == ARB_FULL || arb == ARB_MATCH) && ld_valid_i;
`endif
  end

`ifdef STORE_FWD_EN
  assign unusedBits = ^st_addr_i[1:0];
`else
  assign unusedBits = ^{st_addr_i[1:0], matchData};
`endif

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      entryAddr_q[tail_q] <= st_addr_i[AW-1:2];
      entryData_q[tail_q] <= st_data_i;
    end
  end

endmodule
